// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: drains a bank of class FIFOs into one output FIFO.
// Non-empty queues are served in round-robin order, up to MAX_BURST consecutive
// pops per queue. A two-stage pipeline covers the registered read latency of the
// class FIFOs, so a pop in cycle N becomes a push in cycle N+2. Pops stop while the
// output FIFO reports almost_full or full; words already in the pipeline still drain.
module fifo_rr_arbiter #(
   parameter int DATA_SIZE  = 12,
   parameter int NUM_QUEUES = 4,
   parameter int QID_W      = 2,
   parameter int MAX_BURST  = 2
) (
   input  logic                             clk,
   input  logic                             reset_L,
   input  logic [NUM_QUEUES-1:0]            fifo_empty,
   input  logic [NUM_QUEUES*DATA_SIZE-1:0]  fifo_data_out,
   input  logic                             out_almost_full,
   input  logic                             out_full,
   output logic [NUM_QUEUES-1:0]            pop,
   output logic                             push,
   output logic [DATA_SIZE-1:0]             data_out,
   output logic [QID_W-1:0]                 grant_id,
   output logic                             arb_idle
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam logic [2:0] MAX_BURST_C = 3'(MAX_BURST);

   state_t                 state;
   state_t                 state_next;
   logic [QID_W-1:0]       rr_ptr;
   logic [QID_W-1:0]       rr_ptr_next;
   logic [QID_W-1:0]       grant_next;
   logic [2:0]             burst_cnt;
   logic [2:0]             burst_next;

   logic                   pop_valid;
   logic [QID_W-1:0]       pop_idx;

   logic                   v1;
   logic [QID_W-1:0]       sel1;

   logic                   bp;
   logic [NUM_QUEUES-1:0]  eligible;
   logic                   start_found;
   logic [QID_W-1:0]       start_q;
   logic                   next_found;
   logic [QID_W-1:0]       next_q;

   logic [DATA_SIZE-1:0]   words [NUM_QUEUES];

   // First eligible queue scanning start, start+1, ... with natural wrap.
   // The MSB of the result says whether any queue was eligible at all.
   function automatic logic [QID_W:0] scan_from(input logic [NUM_QUEUES-1:0] elig,
                                                input logic [QID_W-1:0]      start);
      logic             found;
      logic [QID_W-1:0] idx;
      logic [QID_W-1:0] pick;
      found = 1'b0;
      pick  = start;
      for (int k = 0; k < NUM_QUEUES; k++) begin
         idx = start + QID_W'(k);
         if (!found && elig[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      return {found, pick};
   endfunction

   for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_words
      assign words[g] = fifo_data_out[g*DATA_SIZE +: DATA_SIZE];
   end

   assign bp       = out_almost_full | out_full;
   assign eligible = ~fifo_empty;

   // A fresh grant from IDLE starts at rr_ptr; a handover starts just after the
   // current owner so that the owner itself is the last candidate considered.
   assign {start_found, start_q} = scan_from(eligible, rr_ptr);
   assign {next_found, next_q}   = scan_from(eligible, grant_id + 1'b1);

   assign arb_idle = (state == IDLE) & ~v1 & ~push;

   // Arbitration state register: owner, burst length and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         grant_id  <= '0;
      end else begin
         state     <= state_next;
         rr_ptr    <= rr_ptr_next;
         burst_cnt <= burst_next;
         grant_id  <= grant_next;
      end
   end

   // Next-state logic: backpressure wins over everything, then the current burst
   // continues, then ownership hands over in the same cycle, else fall back to IDLE.
   always_comb begin
      state_next  = state;
      rr_ptr_next = rr_ptr;
      burst_next  = burst_cnt;
      grant_next  = grant_id;
      pop_valid   = 1'b0;
      pop_idx     = grant_id;
      case (state)
         IDLE: begin
            if (start_found && !bp) begin
               pop_valid  = 1'b1;
               pop_idx    = start_q;
               grant_next = start_q;
               burst_next = 3'd1;
               state_next = BURST;
            end
         end
         BURST: begin
            if (!bp) begin
               if (eligible[grant_id] && (burst_cnt < MAX_BURST_C)) begin
                  pop_valid  = 1'b1;
                  pop_idx    = grant_id;
                  burst_next = burst_cnt + 3'd1;
               end else if (next_found) begin
                  pop_valid  = 1'b1;
                  pop_idx    = next_q;
                  grant_next = next_q;
                  burst_next = 3'd1;
               end else begin
                  rr_ptr_next = grant_id + 1'b1;
                  state_next  = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // One-hot read strobe, held off entirely while reset is asserted.
   always_comb begin
      pop = '0;
      if (reset_L && pop_valid) begin
         pop[pop_idx] = 1'b1;
      end
   end

   // Two-stage data pipeline: remember which queue was read, then capture its
   // word one cycle later when the class FIFO presents it.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         v1       <= 1'b0;
         sel1     <= '0;
         push     <= 1'b0;
         data_out <= '0;
      end else begin
         v1   <= pop_valid;
         sel1 <= pop_idx;
         push <= v1;
         if (v1) begin
            data_out <= words[sel1];
         end
      end
   end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Testbench for fifo_rr_arbiter: models the class FIFOs as queues, predicts the
// output word order from the round-robin/burst rules, and checks pop/push timing.
module tb_fifo_rr_arbiter;

   localparam int DATA_SIZE  = 12;
   localparam int NUM_QUEUES = 4;
   localparam int QID_W      = 2;
   localparam int MAX_BURST  = 2;

   logic                            clk = 1'b0;
   logic                            reset_L;
   logic [NUM_QUEUES-1:0]           fifo_empty;
   logic [NUM_QUEUES*DATA_SIZE-1:0] fifo_data_out;
   logic                            out_almost_full;
   logic                            out_full;
   logic [NUM_QUEUES-1:0]           pop;
   logic                            push;
   logic [DATA_SIZE-1:0]            data_out;
   logic [QID_W-1:0]                grant_id;
   logic                            arb_idle;

   int assertCount = 0;
   int failCount   = 0;
   int modelRr     = 0;

   logic [DATA_SIZE-1:0] fifoQ  [NUM_QUEUES][$];
   logic [DATA_SIZE-1:0] modelQ [NUM_QUEUES][$];
   logic [DATA_SIZE-1:0] expQ[$];
   logic [DATA_SIZE-1:0] gotQ[$];
   logic [NUM_QUEUES-1:0] popTrace[$];
   logic                  pushTrace[$];
   logic [QID_W-1:0]      grantTrace[$];

   typedef struct {
      logic [NUM_QUEUES-1:0] empty;
      logic                  af;
      logic                  full;
      logic [NUM_QUEUES-1:0] expPop;
   } vec_t;

   vec_t vecs[12];

   fifo_rr_arbiter #(
      .DATA_SIZE (DATA_SIZE),
      .NUM_QUEUES(NUM_QUEUES),
      .QID_W     (QID_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk            (clk),
      .reset_L        (reset_L),
      .fifo_empty     (fifo_empty),
      .fifo_data_out  (fifo_data_out),
      .out_almost_full(out_almost_full),
      .out_full       (out_full),
      .pop            (pop),
      .push           (push),
      .data_out       (data_out),
      .grant_id       (grant_id),
      .arb_idle       (arb_idle)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic updateFlags();
      for (int i = 0; i < NUM_QUEUES; i++) begin
         fifo_empty[i] = (fifoQ[i].size() == 0);
      end
   endtask

   function automatic bit allEmpty();
      bit e;
      e = 1'b1;
      for (int i = 0; i < NUM_QUEUES; i++) begin
         if (fifoQ[i].size() != 0) e = 1'b0;
      end
      return e;
   endfunction

   task automatic loadQueue(input int q, input logic [DATA_SIZE-1:0] w);
      fifoQ[q].push_back(w);
      updateFlags();
   endtask

   // One clock: sample pop mid-cycle, then after the edge let the FIFO model
   // serve the reads and record the registered outputs.
   task automatic stepCycle();
      logic [NUM_QUEUES-1:0] p;
      #2;
      p = pop;
      popTrace.push_back(p);
      checkOutput("popOnEmpty", 32'(p & fifo_empty), 32'd0);
      checkOutput("popOneHot", 32'($countones(p) <= 1), 32'd1);
      if (out_almost_full || out_full) checkOutput("popUnderBp", 32'(p), 32'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_QUEUES; i++) begin
         if (p[i] && fifoQ[i].size() > 0) begin
            fifo_data_out[i*DATA_SIZE +: DATA_SIZE] = fifoQ[i].pop_front();
         end
      end
      updateFlags();
      pushTrace.push_back(push);
      grantTrace.push_back(grant_id);
      if (push === 1'b1) gotQ.push_back(data_out);
   endtask

   // Reference order: whole-queue view of round-robin with bursts of MAX_BURST.
   task automatic buildExpected();
      int cur;
      int nxt;
      int taken;
      int remaining;
      bit found;
      expQ.delete();
      remaining = 0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
         modelQ[i] = fifoQ[i];
         remaining += modelQ[i].size();
      end
      if (remaining == 0) return;
      cur = modelRr;
      found = 1'b0;
      for (int k = 0; k < NUM_QUEUES; k++) begin
         if (!found && modelQ[(modelRr + k) % NUM_QUEUES].size() > 0) begin
            cur = (modelRr + k) % NUM_QUEUES;
            found = 1'b1;
         end
      end
      while (remaining > 0) begin
         taken = 0;
         while (taken < MAX_BURST && modelQ[cur].size() > 0) begin
            expQ.push_back(modelQ[cur].pop_front());
            taken++;
            remaining--;
         end
         if (remaining > 0) begin
            found = 1'b0;
            nxt = cur;
            for (int k = 1; k <= NUM_QUEUES; k++) begin
               if (!found && modelQ[(cur + k) % NUM_QUEUES].size() > 0) begin
                  nxt = (cur + k) % NUM_QUEUES;
                  found = 1'b1;
               end
            end
            cur = nxt;
         end
      end
      modelRr = (cur + 1) % NUM_QUEUES;
   endtask

   // Run until every queue is drained and the arbiter is idle, then score the words.
   task automatic runDrain(input int maxSteps, input bit randomBp, input logic [31:0] bpMask);
      int steps;
      bit done;
      popTrace.delete();
      pushTrace.delete();
      grantTrace.delete();
      gotQ.delete();
      steps = 0;
      done = 1'b0;
      while (!done && steps < maxSteps) begin
         if (randomBp) begin
            out_almost_full = ($urandom_range(0, 99) < 25);
            out_full        = ($urandom_range(0, 99) < 5);
         end else begin
            out_almost_full = (steps < 32) ? bpMask[steps] : 1'b0;
            out_full        = 1'b0;
         end
         stepCycle();
         steps++;
         done = allEmpty() && (arb_idle === 1'b1);
      end
      out_almost_full = 1'b0;
      out_full = 1'b0;
      checkOutput("drainDone", 32'(done), 32'd1);
      checkOutput("wordCount", 32'(gotQ.size()), 32'(expQ.size()));
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
         checkOutput($sformatf("word%0d", i), 32'(gotQ[i]), 32'(expQ[i]));
      end
   endtask

   task automatic doReset(input int cycles);
      for (int i = 0; i < NUM_QUEUES; i++) fifoQ[i].delete();
      updateFlags();
      out_almost_full = 1'b0;
      out_full = 1'b0;
      reset_L = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
      reset_L = 1'b1;
      modelRr = 0;
   endtask

   // Drive one table vector combinationally in IDLE (rr_ptr=0), then restore quiet inputs before the edge.
   task automatic applyStimulus(input vec_t v, input int idx);
      fifo_empty = v.empty;
      out_almost_full = v.af;
      out_full = v.full;
      #1;
      checkOutput($sformatf("tablePop%0d", idx), 32'(pop), 32'(v.expPop));
      checkOutput($sformatf("tableIdle%0d", idx), 32'(arb_idle), 32'd1);
      updateFlags();
      out_almost_full = 1'b0;
      out_full = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Main test sequence.
   initial begin
      int cnt;
      reset_L = 1'b0;
      fifo_empty = '1;
      fifo_data_out = '0;
      out_almost_full = 1'b0;
      out_full = 1'b0;

      // Reset with all queues empty.
      repeat (10) begin
         @(posedge clk);
         #1;
         checkOutput("rstPush", 32'(push), 32'd0);
         checkOutput("rstData", 32'(data_out), 32'd0);
         checkOutput("rstIdle", 32'(arb_idle), 32'd1);
         checkOutput("rstGrant", 32'(grant_id), 32'd0);
         #1;
         checkOutput("rstPop", 32'(pop), 32'd0);
      end
      reset_L = 1'b1;
      modelRr = 0;
      @(posedge clk);
      #1;

      // Table of single-cycle grant decisions from IDLE with rr_ptr=0.
      vecs[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0000};
      vecs[1]  = '{4'b1110, 1'b0, 1'b0, 4'b0001};
      vecs[2]  = '{4'b1101, 1'b0, 1'b0, 4'b0010};
      vecs[3]  = '{4'b1011, 1'b0, 1'b0, 4'b0100};
      vecs[4]  = '{4'b0111, 1'b0, 1'b0, 4'b1000};
      vecs[5]  = '{4'b0000, 1'b0, 1'b0, 4'b0001};
      vecs[6]  = '{4'b0011, 1'b0, 1'b0, 4'b0100};
      vecs[7]  = '{4'b0000, 1'b1, 1'b0, 4'b0000};
      vecs[8]  = '{4'b0000, 1'b0, 1'b1, 4'b0000};
      vecs[9]  = '{4'b1001, 1'b0, 1'b0, 4'b0010};
      vecs[10] = '{4'b0110, 1'b1, 1'b1, 4'b0000};
      vecs[11] = '{4'b0101, 1'b0, 1'b0, 4'b0010};
      for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

      // Sole eligible queue re-granted after its burst limit.
      doReset(2);
      loadQueue(0, 12'h00A);
      loadQueue(0, 12'h00B);
      loadQueue(0, 12'h00C);
      buildExpected();
      runDrain(50, 1'b0, 32'd0);
      for (int k = 0; k < 3; k++) checkOutput($sformatf("t2Pop%0d", k), 32'(popTrace[k]), 32'h1);
      checkOutput("t2PopEnd", 32'(popTrace[3]), 32'h0);
      checkOutput("t2PushEarly", 32'(pushTrace[0]), 32'd0);
      for (int k = 1; k < 4; k++) checkOutput($sformatf("t2Push%0d", k), 32'(pushTrace[k]), 32'd1);
      checkOutput("t2PushEnd", 32'(pushTrace[4]), 32'd0);

      // All queues, two words each: full rotation with no bubbles.
      doReset(2);
      for (int q = 0; q < NUM_QUEUES; q++)
         for (int j = 0; j < 2; j++) loadQueue(q, 12'(q * 16 + j));
      buildExpected();
      runDrain(50, 1'b0, 32'd0);
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("t3Pop%0d", k), 32'(popTrace[k]), 32'(1 << (k / 2)));
         checkOutput($sformatf("t3Grant%0d", k), 32'(grantTrace[k]), 32'(k / 2));
         checkOutput($sformatf("t3Push%0d", k + 1), 32'(pushTrace[k + 1]), 32'd1);
      end

      // Same load with almost_full held for 5 cycles after the third pop.
      doReset(2);
      for (int q = 0; q < NUM_QUEUES; q++)
         for (int j = 0; j < 2; j++) loadQueue(q, 12'(q * 16 + j));
      buildExpected();
      runDrain(60, 1'b0, 32'h0000_00F8);
      cnt = 0;
      for (int k = 3; k < 8; k++) begin
         checkOutput($sformatf("t4PopBp%0d", k), 32'(popTrace[k]), 32'h0);
         checkOutput($sformatf("t4GrantBp%0d", k), 32'(grantTrace[k]), 32'd1);
      end
      for (int k = 2; k < 7; k++) cnt += int'(pushTrace[k]);
      checkOutput("t4DrainPushes", 32'(cnt), 32'd2);
      checkOutput("t4Resume", 32'(popTrace[8]), 32'h2);

      // Wrap-around: end a burst on queue 1 so rr_ptr=2, then serve queues 3 and 1.
      doReset(2);
      loadQueue(1, 12'h111);
      buildExpected();
      runDrain(30, 1'b0, 32'd0);
      loadQueue(1, 12'h222);
      loadQueue(3, 12'h333);
      buildExpected();
      runDrain(30, 1'b0, 32'd0);
      checkOutput("t5First", 32'(popTrace[0]), 32'h8);
      checkOutput("t5Second", 32'(popTrace[1]), 32'h2);

      // Reset while words are in flight.
      doReset(1);
      for (int j = 0; j < 4; j++) loadQueue(0, 12'(12'h600 + j));
      for (int q = 1; q < NUM_QUEUES; q++)
         for (int j = 0; j < 2; j++) loadQueue(q, 12'(q * 256 + j));
      repeat (3) stepCycle();
      reset_L = 1'b0;
      stepCycle();
      checkOutput("t6PopInReset", 32'(popTrace[popTrace.size() - 1]), 32'h0);
      checkOutput("t6PushAfterReset", 32'(push), 32'd0);
      checkOutput("t6IdleAfterReset", 32'(arb_idle), 32'd1);
      reset_L = 1'b1;
      modelRr = 0;
      buildExpected();
      runDrain(60, 1'b0, 32'd0);
      checkOutput("t6RestartQ0", 32'(popTrace[0]), 32'h1);

      // Randomized contents and backpressure against the reference order.
      doReset(2);
      for (int iter = 0; iter < 20; iter++) begin
         for (int q = 0; q < NUM_QUEUES; q++) begin
            cnt = int'($urandom_range(0, 5));
            for (int j = 0; j < cnt; j++) loadQueue(q, 12'($urandom_range(0, 4095)));
         end
         buildExpected();
         runDrain(300, 1'b1, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
